// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780-compatible character-LCD controller for an 8- or 4-bit bus.
// Runs the power-on init sequence by itself, then accepts writes via valid/ready.
module lcd_ctrl #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BUS_WIDTH  = 8,
  parameter int LINES      = 2,
  parameter int POWERON_US = 40_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  output logic       init_done,
  output logic [7:0] data,
  output logic       EN,
  output logic       RW,
  output logic       RS
);

  localparam int T_US    = CLK_HZ / 1_000_000;
  localparam int EN_CYC  = (T_US / 2 > 1) ? T_US / 2 : 1;
  localparam int PWR_CYC = (POWERON_US * T_US > 0) ? POWERON_US * T_US : 1;
  localparam int MAX_CYC = (PWR_CYC > 4100 * T_US) ? PWR_CYC : 4100 * T_US;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int N_INIT  = (BUS_WIDTH == 4) ? 8 : 7;

  localparam logic [CW-1:0] PWR_LIM   = CW'(PWR_CYC - 1);
  localparam logic [CW-1:0] SETUP_LIM = CW'(1);
  localparam logic [CW-1:0] EN_LIM    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] GAP_LIM   = CW'(T_US - 1);
  localparam logic [3:0]    STEP_END  = 4'(N_INIT);
  localparam logic [7:0]    FSET      = ((BUS_WIDTH == 4) ? 8'h20 : 8'h30) |
                                        ((LINES == 2) ? 8'h08 : 8'h00);

  // state      | meaning
  // POWER_WAIT | waiting out the LCD power-on time after reset
  // IDLE       | initialised, req_ready high, waiting for a request
  // SETUP      | data/RS settled on the bus, EN low
  // PULSE      | EN high
  // GAP        | 4-bit only: pause between high-nibble and low-nibble strobes
  // EXEC_WAIT  | instruction execution time; then next init write or IDLE
  // Init writes are launched from the edge that ends POWER_WAIT/EXEC_WAIT,
  // so stepping through the init table costs no extra cycle.
  typedef enum logic [2:0] {
    ST_POWER_WAIT,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_GAP,
    ST_EXEC_WAIT
  } state_t;

  typedef struct packed {
    logic        nib;
    logic [7:0]  byte_v;
    logic [12:0] us;
  } init_t;

  function automatic init_t init_rom(input logic [3:0] idx);
    init_t e;
    e = '{nib: 1'b0, byte_v: 8'h06, us: 13'd40};
    if (BUS_WIDTH == 4) begin
      case (idx)
        4'd0: e = '{1'b1, 8'h30, 13'd4100};
        4'd1: e = '{1'b1, 8'h30, 13'd100};
        4'd2: e = '{1'b1, 8'h30, 13'd40};
        4'd3: e = '{1'b1, 8'h20, 13'd40};
        4'd4: e = '{1'b0, FSET,  13'd40};
        4'd5: e = '{1'b0, 8'h0C, 13'd40};
        4'd6: e = '{1'b0, 8'h01, 13'd1640};
        default: ;
      endcase
    end else begin
      case (idx)
        4'd0: e = '{1'b0, 8'h30, 13'd4100};
        4'd1: e = '{1'b0, 8'h30, 13'd100};
        4'd2: e = '{1'b0, 8'h30, 13'd40};
        4'd3: e = '{1'b0, FSET,  13'd40};
        4'd4: e = '{1'b0, 8'h0C, 13'd40};
        4'd5: e = '{1'b0, 8'h01, 13'd1640};
        default: ;
      endcase
    end
    return e;
  endfunction

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_lim;
  logic [3:0]    r_lo_nib;
  logic          r_two;
  logic [3:0]    r_step;

  init_t         w_rom;
  logic          w_ld_rs;
  logic [7:0]    w_ld_byte;
  logic [12:0]   w_ld_us;
  logic          w_ld_nib;
  logic [CW-1:0] w_ld_lim;
  logic [7:0]    w_ld_bus;
  logic          w_ld_two;
  logic          w_load;

  assign w_rom = init_rom(r_step);
  assign RW    = 1'b0;

  // Next write comes from the init table until init completes, then from the user.
  always_comb begin
    w_ld_rs   = 1'b0;
    w_ld_byte = w_rom.byte_v;
    w_ld_us   = w_rom.us;
    w_ld_nib  = w_rom.nib;
    if (init_done) begin
      w_ld_rs   = req_rs;
      w_ld_byte = req_data;
      w_ld_nib  = 1'b0;
      w_ld_us   = (!req_rs && (req_data inside {8'h01, 8'h02, 8'h03})) ? 13'd1640 : 13'd40;
    end
    w_ld_lim = CW'(32'(w_ld_us) * 32'(T_US) - 32'd1);
    w_ld_bus = (BUS_WIDTH == 4) ? {w_ld_byte[7:4], 4'h0} : w_ld_byte;
    w_ld_two = (BUS_WIDTH == 4) && !w_ld_nib;
  end

  always_comb begin
    w_load = 1'b0;
    case (r_state)
      ST_POWER_WAIT: w_load = (r_cnt == PWR_LIM);
      ST_IDLE:       w_load = req_valid && req_ready;
      ST_EXEC_WAIT:  w_load = (r_cnt == r_lim) && !init_done && (r_step != STEP_END);
      default:       w_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_POWER_WAIT;
      r_cnt     <= '0;
      r_lim     <= '0;
      r_lo_nib  <= 4'h0;
      r_two     <= 1'b0;
      r_step    <= 4'h0;
      data      <= 8'h00;
      EN        <= 1'b0;
      RS        <= 1'b0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else if (w_load) begin
      r_state   <= ST_SETUP;
      r_cnt     <= '0;
      r_lim     <= w_ld_lim;
      data      <= w_ld_bus;
      RS        <= w_ld_rs;
      r_lo_nib  <= w_ld_byte[3:0];
      r_two     <= w_ld_two;
      req_ready <= 1'b0;
      if (!init_done) r_step <= r_step + 4'd1;
    end else begin
      case (r_state)
        ST_POWER_WAIT: r_cnt <= r_cnt + 1'b1;
        ST_SETUP: begin
          if (r_cnt == SETUP_LIM) begin
            EN      <= 1'b1;
            r_cnt   <= '0;
            r_state <= ST_PULSE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PULSE: begin
          if (r_cnt == EN_LIM) begin
            EN      <= 1'b0;
            r_cnt   <= '0;
            r_state <= r_two ? ST_GAP : ST_EXEC_WAIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_cnt == GAP_LIM) begin
            data    <= {r_lo_nib, 4'h0};
            r_two   <= 1'b0;
            r_cnt   <= '0;
            r_state <= ST_SETUP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_EXEC_WAIT: begin
          if (r_cnt == r_lim) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: an 8-bit and a 4-bit instance side by side; expected EN
// strobes are queued by the stimulus and checked by a monitor as they appear.
module tb_lcd_ctrl;

  localparam int CLK_HZ = 4_000_000;
  localparam int T_US   = 4;
  localparam int EN_CYC = 2;
  localparam int PWR_US = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid [2];
  logic       req_rs    [2];
  logic [7:0] req_data  [2];
  logic       req_ready [2];
  logic       init_done [2];
  logic [7:0] bus       [2];
  logic       en        [2];
  logic       rw        [2];
  logic       rs        [2];

  lcd_ctrl #(.CLK_HZ(CLK_HZ), .BUS_WIDTH(8), .LINES(2), .POWERON_US(PWR_US)) u_lcd8 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_rs(req_rs[0]), .req_data(req_data[0]), .init_done(init_done[0]),
    .data(bus[0]), .EN(en[0]), .RW(rw[0]), .RS(rs[0]));

  lcd_ctrl #(.CLK_HZ(CLK_HZ), .BUS_WIDTH(4), .LINES(2), .POWERON_US(PWR_US)) u_lcd4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_rs(req_rs[1]), .req_data(req_data[1]), .init_done(init_done[1]),
    .data(bus[1]), .EN(en[1]), .RW(rw[1]), .RS(rs[1]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       rs_v;
    logic [7:0] bus_v;
    int         rise;
  } pulse_t;

  pulse_t q0[$];
  pulse_t q1[$];
  int vectors = 0;
  int miscompares = 0;

  logic       prev_en  [2] = '{1'b0, 1'b0};
  logic       rdy_early[2] = '{1'b0, 1'b0};
  int         rise_at  [2] = '{0, 0};
  pulse_t     cur      [2];

  // Reference init tables: byte, execution time in us, and whether the 4-bit
  // entry is a full byte (two strobes) or a single nibble.
  logic [7:0] INIT8_B [7] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h0C, 8'h01, 8'h06};
  int         INIT8_US[7] = '{4100, 100, 40, 40, 40, 1640, 40};
  logic [7:0] INIT4_B [8] = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h28, 8'h0C, 8'h01, 8'h06};
  bit         INIT4_2 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  int         INIT4_US[8] = '{4100, 100, 40, 40, 40, 40, 1640, 40};

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic check_true(input string name, input bit cond);
    vectors++;
    if (!cond) begin
      miscompares++;
      $display("FAIL %s: condition false at cycle %0d", name, cyc);
    end
  endtask

  function automatic int qsize(input int w);
    return (w == 0) ? q0.size() : q1.size();
  endfunction

  function automatic void qpush(input int w, input logic r, input logic [7:0] b, input int t);
    pulse_t p;
    p.rs_v = r; p.bus_v = b; p.rise = t;
    if (w == 0) q0.push_back(p); else q1.push_back(p);
  endfunction

  function automatic pulse_t qpop(input int w);
    if (w == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic int exec_cyc(input logic r, input logic [7:0] b);
    return (!r && b >= 8'h01 && b <= 8'h03) ? 1640 * T_US : 40 * T_US;
  endfunction

  // Queue the whole init strobe sequence; returns the cycle init_done should rise.
  function automatic int push_init(input int w, input int rel);
    int r, r2, fall, done, us;
    r = rel + PWR_US * T_US + 2;
    done = 0;
    for (int k = 0; k < ((w == 0) ? 7 : 8); k++) begin
      if (w == 0) begin
        qpush(w, 1'b0, INIT8_B[k], r);
        fall = r + EN_CYC;
        us = INIT8_US[k];
      end else begin
        qpush(w, 1'b0, {INIT4_B[k][7:4], 4'h0}, r);
        fall = r + EN_CYC;
        if (INIT4_2[k]) begin
          r2 = r + EN_CYC + T_US + 2;
          qpush(w, 1'b0, {INIT4_B[k][3:0], 4'h0}, r2);
          fall = r2 + EN_CYC;
        end
        us = INIT4_US[k];
      end
      done = fall + us * T_US;
      r = done + 2;
    end
    return done;
  endfunction

  task automatic mon(input int w);
    pulse_t p;
    if (!rst_n) begin
      prev_en[w] = 1'b0;
    end else begin
      if (!init_done[w] && req_ready[w]) rdy_early[w] = 1'b1;
      if (en[w] && !prev_en[w]) begin
        rise_at[w] = cyc;
        check_true($sformatf("dut%0d EN pulse with empty expectation queue", w), qsize(w) != 0);
        if (qsize(w) != 0) begin
          p = qpop(w);
          cur[w] = p;
          check($sformatf("dut%0d EN rise cycle", w), cyc, p.rise);
          check($sformatf("dut%0d data at rise", w), int'(bus[w]), int'(p.bus_v));
          check($sformatf("dut%0d RS at rise", w), int'(rs[w]), int'(p.rs_v));
          check($sformatf("dut%0d RW", w), int'(rw[w]), 0);
        end
      end else if (!en[w] && prev_en[w]) begin
        check($sformatf("dut%0d EN width", w), cyc - rise_at[w], EN_CYC);
        check($sformatf("dut%0d data held at fall", w), int'(bus[w]), int'(cur[w].bus_v));
      end
      prev_en[w] = en[w];
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic check_zero(input int w);
    check($sformatf("dut%0d reset data", w), int'(bus[w]), 0);
    check($sformatf("dut%0d reset EN", w), int'(en[w]), 0);
    check($sformatf("dut%0d reset RS", w), int'(rs[w]), 0);
    check($sformatf("dut%0d reset RW", w), int'(rw[w]), 0);
    check($sformatf("dut%0d reset req_ready", w), int'(req_ready[w]), 0);
    check($sformatf("dut%0d reset init_done", w), int'(init_done[w]), 0);
  endtask

  task automatic wait_init(input int w, input int exp_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40000 && !ok; i++) begin
      @(negedge clk);
      if (init_done[w]) ok = 1'b1;
    end
    check_true($sformatf("dut%0d init_done within bound", w), ok);
    if (ok) begin
      check($sformatf("dut%0d init_done cycle", w), cyc, exp_cyc);
      check($sformatf("dut%0d req_ready at init_done", w), int'(req_ready[w]), 1);
      check_true($sformatf("dut%0d req_ready low throughout init", w), !rdy_early[w]);
    end
  endtask

  // Called at a negedge; returns at the negedge where req_ready is back high,
  // leaving req_valid asserted with junk so a follow-up call goes back-to-back.
  task automatic send(input int w, input logic r, input logic [7:0] b);
    bit ok;
    int t, busy_exp;
    req_valid[w] = 1'b1;
    req_rs[w]    = r;
    req_data[w]  = b;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (req_ready[w]) ok = 1'b1;
      else @(negedge clk);
    end
    check_true($sformatf("dut%0d ready for request 0x%0h", w, b), ok);
    if (!ok) return;
    t = cyc + 1;
    if (w == 0) begin
      qpush(w, r, b, t + 2);
      busy_exp = 2 + EN_CYC + exec_cyc(r, b);
    end else begin
      qpush(w, r, {b[7:4], 4'h0}, t + 2);
      qpush(w, r, {b[3:0], 4'h0}, t + 2 + EN_CYC + T_US + 2);
      busy_exp = 2 + EN_CYC + T_US + 2 + EN_CYC + exec_cyc(r, b);
    end
    @(negedge clk);
    req_rs[w]   = 1'($urandom_range(0, 1));
    req_data[w] = 8'($urandom);
    ok = 1'b0;
    for (int i = 0; i < 8000 && !ok; i++) begin
      if (req_ready[w]) ok = 1'b1;
      else @(negedge clk);
    end
    check_true($sformatf("dut%0d ready returns after 0x%0h", w, b), ok);
    if (ok) check($sformatf("dut%0d busy cycles rs=%0d byte=0x%0h", w, r, b), cyc - t, busy_exp);
  endtask

  task automatic seq(input int w);
    logic       r;
    logic [7:0] b;
    send(w, 1'b1, 8'h48);
    send(w, 1'b1, 8'h6C);
    send(w, 1'b0, 8'h01);
    send(w, 1'b1, 8'h01);
    send(w, 1'b0, 8'h02);
    for (int i = 0; i < 10; i++) begin
      r = 1'($urandom_range(0, 1));
      b = 8'($urandom);
      send(w, r, b);
    end
    req_valid[w] = 1'b0;
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, d0, d1;
    bit ok;
    for (int w = 0; w < 2; w++) begin
      req_valid[w] = 1'b1;
      req_rs[w]    = 1'b1;
      req_data[w]  = 8'hA5;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero(0);
    check_zero(1);

    rst_n = 1'b1;
    rel = cyc;
    d0 = push_init(0, rel);
    d1 = push_init(1, rel);
    fork
      begin wait_init(0, d0); seq(0); end
      begin wait_init(1, d1); seq(1); end
    join
    repeat (5) @(negedge clk);

    // Reset while the 8-bit instance is mid-strobe.
    req_valid[0] = 1'b1;
    req_rs[0]    = 1'b1;
    req_data[0]  = 8'h55;
    check_true("dut0 idle before reset test", req_ready[0]);
    qpush(0, 1'b1, 8'h55, cyc + 3);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (en[0]) ok = 1'b1;
    end
    check_true("dut0 EN reached before reset", ok);
    #1 rst_n = 1'b0;
    #1;
    check_zero(0);
    check_zero(1);
    q0.delete();
    q1.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rdy_early[0] = 1'b0;
    rdy_early[1] = 1'b0;
    rel = cyc;
    d0 = push_init(0, rel);
    d1 = push_init(1, rel);
    fork
      begin wait_init(0, d0); send(0, 1'b1, 8'h3A); req_valid[0] = 1'b0; end
      begin wait_init(1, d1); send(1, 1'b1, 8'hC5); req_valid[1] = 1'b0; end
    join
    repeat (20) @(negedge clk);
    check("dut0 leftover expected strobes", q0.size(), 0);
    check("dut1 leftover expected strobes", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
